alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that decodes one 16-bit instruction at a time and drives the register file, A/B/C pipeline registers, shifter, ALU and status register.
- Moore FSM. Uses a start/waiting handshake with the instruction source.
- Sequences read-A, read-B, compute and write-back so the shared ALU performs one operation per instruction.
- Sits between the instruction register/fetch logic and the datapath.

Parameters:
- DATA_W, 16, datapath width; sets the width of the sign-extended immediate output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  instruction valid; sampled only in WAIT.
- instr  in  16  instruction; latched into internal ir on accepted start.
- waiting  out  1  high only in WAIT.
- illegal  out  1  high during the DECODE cycle of an unrecognised encoding.
- r_addr  out  3  register-file read address.
- w_addr  out  3  register-file write address.
- w_en  out  1  register-file write enable.
- wb_sel  out  1  write-back source: 0 = C register, 1 = sximm8.
- en_A, en_B, en_C, en_status  out  1 each  load enables.
- sel_A  out  1  1 forces ALU input A to zero.
- shift_op  out  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- ALU_op  out  2  00 add, 01 sub, 10 and, 11 not-B.
- sximm8  out  DATA_W  sign-extended ir[7:0].

Behaviour:
- Instruction fields:
  - opcode = ir[15:13], op = ir[12:11], Rn = ir[10:8], Rd = ir[7:5], sh = ir[4:3], Rm = ir[2:0].
- Legal encodings (anything else is illegal):
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
- States: WAIT, DECODE, LOAD_A, LOAD_B, COMPUTE, WRITE_REG, WRITE_IMM.
- Output defaults: every output not listed for a state is 0. sximm8 always reflects ir.
- WAIT:
  - waiting = 1.
  - start = 1 → ir <= instr, next DECODE. Otherwise stay.
- DECODE: no datapath enables. Next state:
  - MOV imm → WRITE_IMM
  - MOV reg or MVN → LOAD_B
  - ADD/CMP/AND → LOAD_A
  - illegal → WAIT, with illegal = 1 this cycle.
- LOAD_A: r_addr = Rn, en_A = 1 → LOAD_B.
- LOAD_B: r_addr = Rm, en_B = 1 → COMPUTE.
- COMPUTE:
  - shift_op = sh.
  - ALU_op: op for ADD/CMP/AND/MVN; 00 for MOV reg.
  - sel_A = 1 for MOV reg and MVN.
  - CMP: en_status = 1, en_C = 0, next WAIT.
  - All others: en_C = 1, en_status = 0, next WRITE_REG.
- WRITE_REG: w_addr = Rd, wb_sel = 0, w_en = 1 → WAIT.
- WRITE_IMM: w_addr = Rn, wb_sel = 1, w_en = 1 → WAIT.
- Latency, counted as cycles after the accepting edge until the write or status-load cycle:
  - MOV imm: 1
  - MOV reg / MVN: 3
  - ADD / AND: 4
  - CMP: 3 (status-load cycle)
  - waiting reasserts the cycle after the last active state.
- start outside WAIT is ignored; ir holds for the whole instruction.
- Back-to-back: start held high in WAIT is accepted every time the FSM returns to WAIT. There is no bubble beyond the WAIT cycle.
- Reset:
  - rst = 1 at any edge, including mid-instruction: state <= WAIT, ir <= 0.
  - All outputs are 0 except waiting = 1; sximm8 = 0.
  - rst has priority over start.
  - A reset during WRITE_* does not block the write already presented that cycle.
- Register addresses 0..7 all legal; R7 is not special.

Decomposition:
- Shared package alu_seq_pkg:
  - state enum
  - opcode/op localparams (OPC_MOV = 3'b110, OPC_ALU = 3'b101, OP_ADD, OP_CMP, OP_AND, OP_MVN, OP_MOVI = 2'b10, OP_MOVR = 2'b00)
  - shift_op and ALU_op encodings
- One sub-module, instr_dec: purely combinational field extraction, classification, legality and sximm8. The FSM lives in alu_sequencer.

Test Plan:
- Reset, then instr = 16'hD007 (MOV R0,#7), start pulse → DECODE next cycle; WRITE_IMM one cycle later with w_en = 1, w_addr = 0, wb_sel = 1, sximm8 = 16'h0007; waiting = 1 one cycle later.
- 16'hD1FD (MOV R1,#-3) → sximm8 = 16'hFFFD, w_addr = 1.
- 16'hA148 (ADD R2,R1,R0 LSL) → LOAD_A r_addr = 1 en_A; LOAD_B r_addr = 0 en_B; COMPUTE ALU_op = 00 shift_op = 01 en_C; WRITE_REG w_addr = 2. Exactly 6 cycles from accept to waiting.
- 16'hAB04 (CMP R3,R4) → COMPUTE with ALU_op = 01, en_status = 1, en_C = 0; no w_en pulse at any point; returns to WAIT.
- 16'hC0BE (MOV R5,R6 ASR) → LOAD_A skipped; r_addr = 6; sel_A = 1, ALU_op = 00, shift_op = 11; w_addr = 5. 16'hE000 → illegal = 1 for one cycle, no enables, back to WAIT.
- Start held high through a stream of instructions, with rst asserted during LOAD_B of an ADD → next cycle WAIT, all enables 0, no write. start changes mid-instruction do not alter r_addr/w_addr.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and encodings for the ALU sequencer.
//   state_t  - FSM states
//   kind_t   - decoded instruction class
//   dec_t    - decoded instruction fields latched as the internal ir
package alu_seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_AW  = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_WRITE_REG,
    S_WRITE_IMM
  } state_t;

  // K_ILLEGAL is the all-zero encoding so a cleared ir reads as "no instruction"
  typedef enum logic [2:0] {
    K_ILLEGAL,
    K_MOVI,
    K_MOVR,
    K_ADD,
    K_CMP,
    K_AND,
    K_MVN
  } kind_t;

  typedef struct packed {
    kind_t             kind;
    logic [1:0]        op;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rd;
    logic [1:0]        sh;
    logic [REG_AW-1:0] rm;
  } dec_t;

endpackage

// File: rtl/alu_sequencer_instr_dec.sv
// instr_dec: combinational field extraction, classification and immediate
// sign extension for one 16-bit instruction.
//   instr    - raw instruction word
//   dec_c    - class plus op/Rn/Rd/sh/Rm fields
//   legal_c  - encoding is one of the six supported instructions
//   sximm8_c - instr[7:0] sign-extended to DATA_W
module instr_dec
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec_c,
  output logic               legal_c,
  output logic [DATA_W-1:0]  sximm8_c
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = instr[15:13];
  assign op  = instr[12:11];

  // Classification from opcode/op
  always_comb begin
    dec_c      = '0;
    dec_c.kind = K_ILLEGAL;
    dec_c.op   = op;
    dec_c.rn   = instr[10:8];
    dec_c.rd   = instr[7:5];
    dec_c.sh   = instr[4:3];
    dec_c.rm   = instr[2:0];
    if (opc == OPC_MOV) begin
      if (op == OP_MOVI) begin
        dec_c.kind = K_MOVI;
      end else if (op == OP_MOVR) begin
        dec_c.kind = K_MOVR;
      end
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  dec_c.kind = K_ADD;
        OP_CMP:  dec_c.kind = K_CMP;
        OP_AND:  dec_c.kind = K_AND;
        default: dec_c.kind = K_MVN;
      endcase
    end
  end

  assign legal_c  = (dec_c.kind != K_ILLEGAL);
  assign sximm8_c = {{(DATA_W - 8){instr[7]}}, instr[7:0]};

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle Moore controller that steps one instruction
// through read-A, read-B, compute and write-back on a shared datapath.
//   clk, rst          - clock, synchronous active-high reset
//   start, instr      - instruction handshake, accepted only while waiting
//   waiting, illegal  - idle indication, unrecognised-encoding flag
//   r_addr, w_addr    - register-file read/write addresses
//   w_en, wb_sel      - register write enable and source (0 = C, 1 = sximm8)
//   en_A/B/C/status   - datapath load enables
//   sel_A             - zero the ALU A input
//   shift_op, ALU_op  - shifter and ALU controls
//   sximm8            - sign-extended ir[7:0]
// All outputs are registered: each transition loads the outputs of the
// state being entered, so they are valid for the whole of that state.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [INSTR_W-1:0]   instr,
  output logic                 waiting,
  output logic                 illegal,
  output logic [REG_AW-1:0]    r_addr,
  output logic [REG_AW-1:0]    w_addr,
  output logic                 w_en,
  output logic                 wb_sel,
  output logic                 en_A,
  output logic                 en_B,
  output logic                 en_C,
  output logic                 en_status,
  output logic                 sel_A,
  output logic [1:0]           shift_op,
  output logic [1:0]           ALU_op,
  output logic [DATA_W-1:0]    sximm8
);

  state_t state;
  dec_t   ir;

  dec_t              in_dec;
  logic              in_legal;
  logic [DATA_W-1:0] in_sximm8;

  // Decode the incoming word; the decoded fields are what ir holds
  instr_dec #(
    .DATA_W (DATA_W)
  ) u_instr_dec (
    .instr    (instr),
    .dec_c    (in_dec),
    .legal_c  (in_legal),
    .sximm8_c (in_sximm8)
  );

  // State register and registered outputs for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT;
      ir        <= '0;
      sximm8    <= '0;
      waiting   <= 1'b1;
      illegal   <= 1'b0;
      r_addr    <= '0;
      w_addr    <= '0;
      w_en      <= 1'b0;
      wb_sel    <= 1'b0;
      en_A      <= 1'b0;
      en_B      <= 1'b0;
      en_C      <= 1'b0;
      en_status <= 1'b0;
      sel_A     <= 1'b0;
      shift_op  <= SH_NONE;
      ALU_op    <= ALU_ADD;
    end else begin
      waiting   <= 1'b0;
      illegal   <= 1'b0;
      r_addr    <= '0;
      w_addr    <= '0;
      w_en      <= 1'b0;
      wb_sel    <= 1'b0;
      en_A      <= 1'b0;
      en_B      <= 1'b0;
      en_C      <= 1'b0;
      en_status <= 1'b0;
      sel_A     <= 1'b0;
      shift_op  <= SH_NONE;
      ALU_op    <= ALU_ADD;

      case (state)
        S_WAIT: begin
          if (start) begin
            ir      <= in_dec;
            sximm8  <= in_sximm8;
            illegal <= ~in_legal;
            state   <= S_DECODE;
          end else begin
            waiting <= 1'b1;
          end
        end

        S_DECODE: begin
          case (ir.kind)
            K_MOVI: begin
              state  <= S_WRITE_IMM;
              w_addr <= ir.rn;
              wb_sel <= 1'b1;
              w_en   <= 1'b1;
            end
            K_MOVR, K_MVN: begin
              state  <= S_LOAD_B;
              r_addr <= ir.rm;
              en_B   <= 1'b1;
            end
            K_ADD, K_CMP, K_AND: begin
              state  <= S_LOAD_A;
              r_addr <= ir.rn;
              en_A   <= 1'b1;
            end
            default: begin
              state   <= S_WAIT;
              waiting <= 1'b1;
            end
          endcase
        end

        S_LOAD_A: begin
          state  <= S_LOAD_B;
          r_addr <= ir.rm;
          en_B   <= 1'b1;
        end

        S_LOAD_B: begin
          state    <= S_COMPUTE;
          shift_op <= ir.sh;
          // MOV reg is 0 + shifted B; MVN uses its own op with A forced to zero
          ALU_op   <= (ir.kind == K_MOVR) ? ALU_ADD : ir.op;
          sel_A    <= (ir.kind == K_MOVR) || (ir.kind == K_MVN);
          if (ir.kind == K_CMP) begin
            en_status <= 1'b1;
          end else begin
            en_C <= 1'b1;
          end
        end

        S_COMPUTE: begin
          if (ir.kind == K_CMP) begin
            state   <= S_WAIT;
            waiting <= 1'b1;
          end else begin
            state  <= S_WRITE_REG;
            w_addr <= ir.rd;
            w_en   <= 1'b1;
          end
        end

        default: begin
          state   <= S_WAIT;
          waiting <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized checks of alu_sequencer against
// a per-instruction list of expected output cycles built from the
// instruction's meaning.
module tb_alu_sequencer;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          waiting;
    logic          illegal;
    logic [2:0]    r_addr;
    logic [2:0]    w_addr;
    logic          w_en;
    logic          wb_sel;
    logic          en_A;
    logic          en_B;
    logic          en_C;
    logic          en_status;
    logic          sel_A;
    logic [1:0]    shift_op;
    logic [1:0]    ALU_op;
    logic [DW-1:0] sximm8;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   instr;
  logic          waiting, illegal, w_en, wb_sel;
  logic          en_A, en_B, en_C, en_status, sel_A;
  logic [2:0]    r_addr, w_addr;
  logic [1:0]    shift_op, ALU_op;
  logic [DW-1:0] sximm8;

  obs_t obs;
  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] last_sx;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .instr     (instr),
    .waiting   (waiting),
    .illegal   (illegal),
    .r_addr    (r_addr),
    .w_addr    (w_addr),
    .w_en      (w_en),
    .wb_sel    (wb_sel),
    .en_A      (en_A),
    .en_B      (en_B),
    .en_C      (en_C),
    .en_status (en_status),
    .sel_A     (sel_A),
    .shift_op  (shift_op),
    .ALU_op    (ALU_op),
    .sximm8    (sximm8)
  );

  assign obs = {waiting, illegal, r_addr, w_addr, w_en, wb_sel, en_A, en_B,
                en_C, en_status, sel_A, shift_op, ALU_op, sximm8};

  function automatic obs_t wait_rec(input logic [DW-1:0] sx);
    obs_t r;
    r         = '0;
    r.waiting = 1'b1;
    r.sximm8  = sx;
    return r;
  endfunction

  // Expected outputs, one entry per cycle after the accepting edge,
  // ending with the WAIT cycle.
  function automatic void model(input logic [15:0] i);
    logic [2:0]    opc = i[15:13];
    logic [1:0]    op  = i[12:11];
    logic [2:0]    rn  = i[10:8];
    logic [2:0]    rd  = i[7:5];
    logic [1:0]    sh  = i[4:3];
    logic [2:0]    rm  = i[2:0];
    logic [DW-1:0] sx  = {{(DW - 8){i[7]}}, i[7:0]};
    bit movi  = (opc == 3'b110) && (op == 2'b10);
    bit movr  = (opc == 3'b110) && (op == 2'b00);
    bit alu   = (opc == 3'b101);
    bit legal = movi || movr || alu;
    bit cmp   = alu && (op == 2'b01);
    bit mvn   = alu && (op == 2'b11);
    obs_t b, r;
    exp_q.delete();
    b        = '0;
    b.sximm8 = sx;
    r         = b;
    r.illegal = !legal;
    exp_q.push_back(r);
    if (legal) begin
      if (movi) begin
        r = b; r.w_en = 1'b1; r.w_addr = rn; r.wb_sel = 1'b1;
        exp_q.push_back(r);
      end else begin
        if (alu && !mvn) begin
          r = b; r.r_addr = rn; r.en_A = 1'b1;
          exp_q.push_back(r);
        end
        r = b; r.r_addr = rm; r.en_B = 1'b1;
        exp_q.push_back(r);
        r = b;
        r.shift_op = sh;
        r.ALU_op   = alu ? op : 2'b00;
        r.sel_A    = movr || mvn;
        if (cmp) r.en_status = 1'b1;
        else     r.en_C      = 1'b1;
        exp_q.push_back(r);
        if (!cmp) begin
          r = b; r.w_addr = rd; r.w_en = 1'b1;
          exp_q.push_back(r);
        end
      end
    end
    exp_q.push_back(wait_rec(sx));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input obs_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Run one instruction from WAIT. hold keeps start high throughout;
  // rst_at applies reset after that expected-cycle index (-1 = never).
  task automatic run_instr(input logic [15:0] i, input bit hold, input int rst_at);
    int n;
    model(i);
    n     = exp_q.size();
    start = 1'b1;
    instr = i;
    step();
    for (int k = 0; k < n; k++) begin
      check($sformatf("i%h_c%0d", i, k), exp_q[k]);
      if (k == rst_at) begin
        rst   = 1'b1;
        instr = 16'($urandom);
        step();
        rst   = 1'b0;
        last_sx = '0;
        check($sformatf("i%h_rst%0d", i, k), wait_rec('0));
        return;
      end
      if (k < n - 1) begin
        start = hold ? 1'b1 : 1'($urandom);
        instr = 16'($urandom);
        step();
      end
    end
    last_sx = {{(DW - 8){i[7]}}, i[7:0]};
    if (!hold) start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      check($sformatf("idle%0d", k), wait_rec(last_sx));
    end
  endtask

  initial begin
    logic [15:0] ri;
    int          r;
    int          ra;
    rst     = 1'b1;
    start   = 1'b1;
    instr   = 16'hD007;
    last_sx = '0;
    step();
    step();
    check("reset", wait_rec('0));
    rst   = 1'b0;
    start = 1'b0;
    idle(2);

    run_instr(16'hD007, 1'b0, -1);
    idle(1);
    run_instr(16'hD1FD, 1'b0, -1);
    run_instr(16'hA148, 1'b0, -1);
    run_instr(16'hAB04, 1'b0, -1);
    run_instr(16'hC0BE, 1'b0, -1);
    run_instr(16'hE000, 1'b0, -1);
    idle(1);

    // Back-to-back stream with start held, reset during LOAD_B of an ADD
    run_instr(16'hA148, 1'b1, -1);
    run_instr(16'hD1FD, 1'b1, -1);
    run_instr(16'hB7E3, 1'b1, -1);
    run_instr(16'hA148, 1'b1, 2);
    run_instr(16'hBFF9, 1'b1, -1);
    run_instr(16'hC0BE, 1'b1, -1);
    idle(2);

    for (int t = 0; t < 60; t++) begin
      ri = 16'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r < 4) begin
        ri[15:13] = 3'b101;
      end else if (r < 7) begin
        ri[15:13] = 3'b110;
        ri[12:11] = r[0] ? 2'b10 : 2'b00;
      end
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ri, 1'($urandom), ra);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
